// File: rtl/perceptron_trainer_seq.sv
// perceptron_trainer_seq: online perceptron trainer/classifier with serial MAC, step activation and error-driven update.
// Optional PERCEPTRON_SAT_EN clamps updated weights/bias instead of wrapping them.
module perceptron_trainer_seq #(
    parameter int DIM      = 4,
    parameter int DW       = 8,
    parameter int WW       = 16,
    parameter int ACC_W    = DW + WW + $clog2(DIM + 2),
    parameter int LR_SHIFT = 0,
    parameter int AW       = $clog2(DIM + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DIM*DW-1:0] s_x,
    input  logic              s_y,
    input  logic              s_train,
    output logic              o_valid,
    output logic              o_pred,
    output logic              o_err,
    input  logic              w_wr_en,
    input  logic [AW-1:0]     w_addr,
    input  logic [WW-1:0]     w_wdata,
    output logic [WW-1:0]     w_rdata,
    output logic [15:0]       upd_cnt,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, MAC, UPD, RESP} state_t;
    state_t state, state_nx;
    logic signed [WW-1:0]    w [DIM+1];
    logic signed [WW-1:0]    w_nx [DIM+1];
    // x_r[DIM] is held at 1 so the bias goes through the same MAC path as the features
    logic signed [DW-1:0]    x_r [DIM+1];
    logic                    y_r, train_r;
    logic [AW-1:0]           k;
    logic signed [ACC_W-1:0] acc;
    logic signed [DW+WW-1:0] prod;
    logic                    hs, pred, err, do_upd;
    assign s_ready = (state == IDLE) && !w_wr_en;
    assign hs      = s_valid && s_ready;
    assign busy    = state != IDLE;
    assign o_valid = state == RESP;
    assign pred    = acc > 0;
    assign err     = pred != y_r;
    assign do_upd  = (state == UPD) && train_r && err;
    assign prod    = x_r[k] * w[k];
    assign w_rdata = (w_addr <= AW'(DIM)) ? w[w_addr] : '0;
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = hs ? MAC : IDLE;
            MAC:     state_nx = (k == AW'(DIM)) ? UPD : MAC;
            UPD:     state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end
    genvar g;
    for (g = 0; g <= DIM; g++) begin : g_upd
        logic signed [DW-1:0] xs;
        logic signed [WW:0]   d, s;
        assign xs = x_r[g] >>> LR_SHIFT;
        assign d  = (g == DIM) ? (WW+1)'(1) : {{(WW+1-DW){xs[DW-1]}}, xs};
        assign s  = {w[g][WW-1], w[g]} + (y_r ? d : -d);
`ifdef PERCEPTRON_SAT_EN
        assign w_nx[g] = (s[WW] ^ s[WW-1]) ? {s[WW], {(WW-1){~s[WW]}}} : s[WW-1:0];
`else
        assign w_nx[g] = s[WW-1:0];
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            acc     <= '0;
            y_r     <= 1'b0;
            train_r <= 1'b0;
            o_pred  <= 1'b0;
            o_err   <= 1'b0;
            upd_cnt <= '0;
            for (int i = 0; i <= DIM; i++) begin
                w[i]   <= '0;
                x_r[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (hs) begin
                for (int i = 0; i < DIM; i++) x_r[i] <= s_x[i*DW +: DW];
                x_r[DIM] <= DW'(1);
                y_r      <= s_y;
                train_r  <= s_train;
                acc      <= '0;
                k        <= '0;
            end
            if (state == MAC) begin
                acc <= acc + ACC_W'(prod);
                k   <= k + 1'b1;
            end
            if (state == IDLE && w_wr_en && w_addr <= AW'(DIM)) w[w_addr] <= w_wdata;
            if (do_upd) begin
                for (int i = 0; i <= DIM; i++) w[i] <= w_nx[i];
                upd_cnt <= upd_cnt + {15'd0, upd_cnt != 16'hFFFF};
            end
            if (state == UPD) begin
                o_pred <= pred;
                o_err  <= err;
            end
        end
    end
endmodule

// File: tb/tb_perceptron_trainer_seq.sv
// tb_perceptron_trainer_seq: directed checks of training, inference, overflow, reset abort and busy behaviour.
module tb_perceptron_trainer_seq;
    localparam int DIM = 2, DW = 8, WW = 16, AW = 2;
    logic clk = 0, rst_n = 0, s_valid = 0, s_y = 0, s_train = 0, w_wr_en = 0;
    logic [DIM*DW-1:0] s_x = '0;
    logic [AW-1:0] w_addr = '0;
    logic [WW-1:0] w_wdata = '0, w_rdata;
    logic s_ready, o_valid, o_pred, o_err, busy;
    logic [15:0] upd_cnt;
    int errors = 0, checks = 0;

    perceptron_trainer_seq #(.DIM(DIM), .DW(DW), .WW(WW), .LR_SHIFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
        .s_train(s_train), .o_valid(o_valid), .o_pred(o_pred), .o_err(o_err), .w_wr_en(w_wr_en),
        .w_addr(w_addr), .w_wdata(w_wdata), .w_rdata(w_rdata), .upd_cnt(upd_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [WW-1:0] v);
        w_addr = a;
        #1;
        v = w_rdata;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WW-1:0] v);
        w_wr_en = 1; w_addr = a; w_wdata = v;
        checks++;
        #1;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL wr_blocks_ready got=%b exp=0", s_ready); end
        tick();
        w_wr_en = 0;
    endtask

    task automatic run_sample(input logic [7:0] x0, input logic [7:0] x1, input logic y, input logic tr,
                              output logic p, output logic e, output int lat);
        int n;
        s_x = {x1, x0}; s_y = y; s_train = tr; s_valid = 1;
        n = 0;
        while (!s_ready && n < 50) begin tick(); n++; end
        tick();
        s_valid = 0;
        lat = 1;
        while (!o_valid && lat < 30) begin tick(); lat++; end
        p = o_pred; e = o_err;
        tick();
    endtask

    task automatic chk_w(input string nm, input logic [AW-1:0] a, input logic [WW-1:0] exp);
        logic [WW-1:0] v;
        rd(a, v);
        checks++;
        if (v !== exp) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, $signed(v), $signed(exp)); end
    endtask

    task automatic test_reset();
        rst_n = 0; tick(); tick(); rst_n = 1; #1;
        checks += 5;
        if (s_ready !== 1) begin errors++; $display("FAIL rst_ready got=%b exp=1", s_ready); end
        if (o_valid !== 0) begin errors++; $display("FAIL rst_ovalid got=%b exp=0", o_valid); end
        if (o_pred !== 0 || o_err !== 0) begin errors++; $display("FAIL rst_pred_err got=%b%b exp=00", o_pred, o_err); end
        if (busy !== 0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (upd_cnt !== 0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", upd_cnt); end
        for (int i = 0; i <= DIM; i++) chk_w("rst_w", AW'(i), 16'd0);
    endtask

    task automatic test_train();
        logic p, e;
        int lat;
        run_sample(8'd2, 8'd3, 1, 1, p, e, lat);
        checks += 3;
        if (lat !== 5) begin errors++; $display("FAIL train1_latency got=%0d exp=5", lat); end
        if (p !== 0) begin errors++; $display("FAIL train1_pred got=%b exp=0", p); end
        if (e !== 1) begin errors++; $display("FAIL train1_err got=%b exp=1", e); end
        chk_w("train1_w0", 0, 16'd2);
        chk_w("train1_w1", 1, 16'd3);
        chk_w("train1_bias", 2, 16'd1);
        checks++;
        if (upd_cnt !== 1) begin errors++; $display("FAIL train1_cnt got=%0d exp=1", upd_cnt); end
        run_sample(8'd2, 8'd3, 1, 1, p, e, lat);
        checks += 3;
        if (p !== 1) begin errors++; $display("FAIL train2_pred got=%b exp=1", p); end
        if (e !== 0) begin errors++; $display("FAIL train2_err got=%b exp=0", e); end
        if (upd_cnt !== 1) begin errors++; $display("FAIL train2_cnt got=%0d exp=1", upd_cnt); end
        chk_w("train2_w0", 0, 16'd2);
        chk_w("train2_bias", 2, 16'd1);
    endtask

    task automatic test_infer();
        logic p, e;
        int lat;
        run_sample(-8'sd4, -8'sd5, 1, 0, p, e, lat);
        checks += 3;
        if (p !== 0) begin errors++; $display("FAIL infer_pred got=%b exp=0", p); end
        if (e !== 1) begin errors++; $display("FAIL infer_err got=%b exp=1", e); end
        if (upd_cnt !== 1) begin errors++; $display("FAIL infer_cnt got=%0d exp=1", upd_cnt); end
        chk_w("infer_w1", 1, 16'd3);
        chk_w("infer_bias", 2, 16'd1);
        repeat (3) tick();
        checks++;
        if (o_pred !== 0 || o_err !== 1) begin errors++; $display("FAIL infer_hold got=%b%b exp=01", o_pred, o_err); end
    endtask

    task automatic test_overflow();
        logic p, e;
        int lat;
        wr(0, 16'h7FFF); wr(1, 16'h8000); wr(2, 16'h0000);
        chk_w("ovf_rd_w0", 0, 16'h7FFF);
        chk_w("ovf_rd_oob", 3, 16'h0000);
        run_sample(8'd1, 8'd2, 1, 1, p, e, lat);
        checks += 2;
        if (p !== 0 || e !== 1) begin errors++; $display("FAIL ovf_pred_err got=%b%b exp=01", p, e); end
        if (upd_cnt !== 2) begin errors++; $display("FAIL ovf_cnt got=%0d exp=2", upd_cnt); end
`ifdef PERCEPTRON_SAT_EN
        chk_w("ovf_w0_sat", 0, 16'h7FFF);
`else
        chk_w("ovf_w0_wrap", 0, 16'h8000);
`endif
        chk_w("ovf_w1", 1, 16'h8002);
        chk_w("ovf_bias", 2, 16'd1);
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        s_x = {8'd1, 8'd1}; s_y = 1; s_train = 1; s_valid = 1;
        tick();
        s_valid = 0;
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            if (o_valid) seen++;
            tick();
        end
        checks += 3;
        if (seen !== 0) begin errors++; $display("FAIL abort_ovalid got=%0d exp=0", seen); end
        if (s_ready !== 1) begin errors++; $display("FAIL abort_ready got=%b exp=1", s_ready); end
        if (upd_cnt !== 0) begin errors++; $display("FAIL abort_cnt got=%0d exp=0", upd_cnt); end
        for (int i = 0; i <= DIM; i++) chk_w("abort_w", AW'(i), 16'd0);
    endtask

    task automatic test_back_to_back();
        int n1 = 0, n2 = 0;
        logic p1 = 0, p2 = 0;
        s_x = {8'd1, 8'd1}; s_y = 1; s_train = 1; s_valid = 1;
        tick();
        for (int n = 1; n <= 20; n++) begin
            if (o_valid && n1 == 0) begin n1 = n; p1 = o_pred; end
            else if (o_valid && n2 == 0) begin n2 = n; p2 = o_pred; end
            if (n == 1) begin
                w_wr_en = 1; w_addr = 0; w_wdata = 16'd100;
                #1;
                checks += 2;
                if (s_ready !== 0) begin errors++; $display("FAIL busy_ready got=%b exp=0", s_ready); end
                if (busy !== 1) begin errors++; $display("FAIL busy_flag got=%b exp=1", busy); end
            end
            if (n == 2) w_wr_en = 0;
            tick();
            if (n == 6) s_valid = 0;
        end
        checks += 4;
        if (n1 !== 5) begin errors++; $display("FAIL b2b_first got=%0d exp=5", n1); end
        if (n2 !== 11) begin errors++; $display("FAIL b2b_second got=%0d exp=11", n2); end
        if (p1 !== 0 || p2 !== 1) begin errors++; $display("FAIL b2b_preds got=%b%b exp=01", p1, p2); end
        if (upd_cnt !== 1) begin errors++; $display("FAIL b2b_cnt got=%0d exp=1", upd_cnt); end
        chk_w("b2b_w0_dropped", 0, 16'd1);
        chk_w("b2b_bias", 2, 16'd1);
    endtask

    initial begin
        tick();
        test_reset();
        test_train();
        test_infer();
        test_overflow();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
